// File: rtl/mem_pkg.sv
// Shared definitions for the data memory controller: access sizes,
// controller states and the latency counter width.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int LAT_W = $clog2(4) + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the 32-bit RAM word and right-aligned request
// data, plus detection of misaligned or reserved-size accesses.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        align_err
);

    logic [4:0]  shift;
    logic [31:0] rshifted;

    assign shift    = {offset, 3'b000};
    assign rshifted = rword >> shift;

    always_comb begin
        byte_en    = '0;
        wdata_lane = '0;
        rdata_ext  = '0;
        align_err  = 1'b0;
        case (size)
            SZ_BYTE: begin
                byte_en    = 4'b0001 << offset;
                wdata_lane = {24'b0, wdata[7:0]} << shift;
                rdata_ext  = is_unsigned ? {24'b0, rshifted[7:0]}
                                         : {{24{rshifted[7]}}, rshifted[7:0]};
            end
            SZ_HALF: begin
                align_err  = offset[0];
                byte_en    = 4'b0011 << offset;
                wdata_lane = {16'b0, wdata[15:0]} << shift;
                rdata_ext  = is_unsigned ? {16'b0, rshifted[15:0]}
                                         : {{16{rshifted[15]}}, rshifted[15:0]};
            end
            SZ_WORD: begin
                align_err  = |offset;
                byte_en    = '1;
                wdata_lane = wdata;
                rdata_ext  = rword;
            end
            default: align_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-outstanding load/store controller in front of the data RAM with
// valid/ready request and response handshakes and configurable read latency.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 256,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t            state, state_n;
    logic [LAT_W-1:0]  cnt, cnt_n;
    logic              accept;
    logic [ADDR_W-3:0] widx;
    logic              out_of_range, align_err, err;
    logic [3:0]        byte_en;
    logic [31:0]       wdata_lane, rword, rdata_ext;
    logic [31:0]       mem [DEPTH];

    assign widx         = req_addr[ADDR_W-1:2];
    assign out_of_range = widx >= (ADDR_W-2)'(DEPTH);
    assign err          = align_err | out_of_range;
    assign rword        = mem[widx[IDX_W-1:0]];

    mem_lane_align u_align (
        .size        (req_size),
        .offset      (req_addr[1:0]),
        .is_unsigned (req_unsigned),
        .wdata       (req_wdata),
        .rword       (rword),
        .byte_en     (byte_en),
        .wdata_lane  (wdata_lane),
        .rdata_ext   (rdata_ext),
        .align_err   (align_err)
    );

    // Load data is captured at accept and simply held until the handshake,
    // so the WAIT cycles only model latency.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: req_ready = 1'b1;
            WAIT: begin
                if (cnt == '0) state_n = RESP;
                else           cnt_n   = cnt - 1'b1;
            end
            RESP: begin
                rsp_valid = 1'b1;
                req_ready = rsp_ready;
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (!reset_n) req_ready = 1'b0;
        accept = req_valid && req_ready;
        if (accept) begin
            state_n = (READ_LAT == 1) ? RESP : WAIT;
            cnt_n   = LAT_W'((READ_LAT > 1) ? READ_LAT - 2 : 0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                rsp_err   <= err;
                rsp_rdata <= (req_we || err) ? '0 : rdata_ext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && req_we && !err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[widx[IDX_W-1:0]][8*i +: 8] <= wdata_lane[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl at read latencies 1, 3 and 4.
module tb_data_mem_ctrl;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we [3];
    logic [1:0]  req_size [3];
    logic        req_unsigned [3];
    logic [31:0] req_addr [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_W(32), .DEPTH(256), .READ_LAT(1)) u_lat1 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_ctrl #(.ADDR_W(32), .DEPTH(256), .READ_LAT(3)) u_lat3 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    data_mem_ctrl #(.ADDR_W(32), .DEPTH(256), .READ_LAT(4)) u_lat4 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_size(req_size[2]), .req_unsigned(req_unsigned[2]), .req_addr(req_addr[2]),
        .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid[d]    = 1'b1;
        req_we[d]       = we;
        req_size[d]     = sz;
        req_unsigned[d] = uns;
        req_addr[d]     = addr;
        req_wdata[d]    = wd;
    endtask

    task automatic accept_wait(input int d);
        int guard;
        guard = 0;
        while (!req_ready[d] && guard < 50) begin
            step();
            guard++;
        end
        step();
    endtask

    task automatic rsp_wait(input int d, output int lat);
        lat = 1;
        while (!rsp_valid[d] && lat < 50) begin
            step();
            lat++;
        end
    endtask

    task automatic do_chk(input string tag, input int d, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_er, input int exp_lat);
        int lat;
        drive(d, we, sz, uns, addr, wd);
        rsp_ready[d] = 1'b1;
        accept_wait(d);
        req_valid[d] = 1'b0;
        rsp_wait(d, lat);
        check({tag, ".rdata"}, rsp_rdata[d], exp_rd);
        check({tag, ".err"}, 32'(rsp_err[d]), 32'(exp_er));
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int seen;
        reset_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            drive(d, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
            req_valid[d] = 1'b0;
            rsp_ready[d] = 1'b0;
        end
        step();
        step();
        check("reset.rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("reset.req_ready", 32'(req_ready[0]), 32'd0);
        check("reset.rsp_rdata", rsp_rdata[0], 32'h0);
        check("reset.rsp_err", 32'(rsp_err[0]), 32'd0);
        reset_n = 1'b1;
        step();
        check("idle.req_ready", 32'(req_ready[0]), 32'd1);

        // Basic word store/load, latency 1
        do_chk("st_word", 0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1);
        do_chk("ld_word", 0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1);

        // Byte and halfword lanes
        do_chk("st_base", 0, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0, 1);
        do_chk("st_byte", 0, 1'b1, SZ_BYTE, 1'b0, 32'h21, 32'hFFFFFF80, 32'h0, 1'b0, 1);
        do_chk("ld_merged", 0, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h11228044, 1'b0, 1);
        do_chk("ld_byte_s", 0, 1'b0, SZ_BYTE, 1'b0, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0, 1);
        do_chk("ld_byte_u", 0, 1'b0, SZ_BYTE, 1'b1, 32'h21, 32'h0, 32'h00000080, 1'b0, 1);
        do_chk("ld_half_hi", 0, 1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0, 32'h00001122, 1'b0, 1);
        do_chk("ld_half_s", 0, 1'b0, SZ_HALF, 1'b0, 32'h20, 32'h0, 32'hFFFF8044, 1'b0, 1);
        do_chk("ld_half_u", 0, 1'b0, SZ_HALF, 1'b1, 32'h20, 32'h0, 32'h00008044, 1'b0, 1);
        do_chk("ld_word_u", 0, 1'b0, SZ_WORD, 1'b1, 32'h20, 32'h0, 32'h11228044, 1'b0, 1);

        // Error cases leave memory untouched
        do_chk("st_half_mis", 0, 1'b1, SZ_HALF, 1'b0, 32'h23, 32'h0000BEEF, 32'h0, 1'b1, 1);
        do_chk("ld_after_mis", 0, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h11228044, 1'b0, 1);
        do_chk("ld_word_mis", 0, 1'b0, SZ_WORD, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 1);
        do_chk("st_last", 0, 1'b1, SZ_WORD, 1'b0, 32'h3FC, 32'hCAFEF00D, 32'h0, 1'b0, 1);
        do_chk("ld_last", 0, 1'b0, SZ_WORD, 1'b0, 32'h3FC, 32'h0, 32'hCAFEF00D, 1'b0, 1);
        do_chk("st_zero", 0, 1'b1, SZ_WORD, 1'b0, 32'h0, 32'h0BADF00D, 32'h0, 1'b0, 1);
        do_chk("st_oor", 0, 1'b1, SZ_WORD, 1'b0, 32'h400, 32'h12345678, 32'h0, 1'b1, 1);
        do_chk("ld_oor", 0, 1'b0, SZ_WORD, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1);
        do_chk("ld_no_alias", 0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 32'h0BADF00D, 1'b0, 1);
        do_chk("ld_size11", 0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1);
        do_chk("st_size11", 0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h01020304, 32'h0, 1'b1, 1);
        do_chk("ld_after_sz11", 0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1);

        // Back-to-back store/load pairs, one access per cycle
        rsp_ready[0] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            drive(0, (k % 2) == 0, SZ_WORD, 1'b0, 32'h100 + 32'(4 * (k / 2)),
                  32'hC0DE0000 | 32'(k / 2));
            step();
            check("b2b.valid_ready", {30'b0, rsp_valid[0], req_ready[0]}, 32'd3);
            if (k % 2 == 1) check("b2b.rdata", rsp_rdata[0], 32'hC0DE0000 | 32'(k / 2));
        end
        req_valid[0] = 1'b0;
        step();
        check("b2b.drain", 32'(rsp_valid[0]), 32'd0);

        // Backpressure at latency 3
        do_chk("bp_store", 1, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'h55AA1234, 32'h0, 1'b0, 3);
        drive(1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
        rsp_ready[1] = 1'b0;
        accept_wait(1);
        drive(1, 1'b0, SZ_BYTE, 1'b1, 32'h41, 32'h0);
        rsp_wait(1, lat);
        check("bp.lat", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp.hold_valid", 32'(rsp_valid[1]), 32'd1);
            check("bp.hold_rdata", rsp_rdata[1], 32'h55AA1234);
            check("bp.hold_ready", 32'(req_ready[1]), 32'd0);
        end
        rsp_ready[1] = 1'b1;
        #1;
        check("bp.ready_follow", 32'(req_ready[1]), 32'd1);
        step();
        req_valid[1] = 1'b0;
        check("bp.same_edge", 32'(rsp_valid[1]), 32'd0);
        rsp_wait(1, lat);
        check("bp.next_lat", 32'(lat), 32'd3);
        check("bp.next_rdata", rsp_rdata[1], 32'h00000012);
        step();

        // Reset while a latency-4 store is still in WAIT
        drive(2, 1'b1, SZ_WORD, 1'b0, 32'h80, 32'hA5A5A5A5);
        rsp_ready[2] = 1'b1;
        accept_wait(2);
        req_valid[2] = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        #1;
        check("rst_mid.valid", 32'(rsp_valid[2]), 32'd0);
        check("rst_mid.ready", 32'(req_ready[2]), 32'd0);
        step();
        step();
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rsp_valid[2]) seen++;
        end
        check("rst_mid.no_rsp", 32'(seen), 32'd0);
        do_chk("rst_mid.load", 2, 1'b0, SZ_WORD, 1'b0, 32'h80, 32'h0, 32'hA5A5A5A5, 1'b0, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
